// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder; ovf is present only
// when DIGIT_SERIAL_ADDER_OVF_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial add/sub of two WIDTH-bit operands, DIGIT bits per cycle (ovf via DIGIT_SERIAL_ADDER_OVF_EN).
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge; one op per NDIG+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE, nothing is queued.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One DIGIT-wide adder slice; the result fills in from the MSB side so the
    // final digit lands the word in place.
    assign dsum      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign sum_shift = (sum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last      = (cnt == CW'(NDIG - 1));

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic carry_msb;

    // Carry into the digit's top bit, recovered from that bit's sum and addends.
    assign carry_msb = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= carry_msb ^ dsum[DIGIT];
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    sum_q <= sum_shift;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout_q <= dsum[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s    = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a DIGIT=4 instance for most scenarios
// and a DIGIT=32 instance for the single-digit case.
module tb_digit_serial_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   compared   = 0;
    int   mismatched = 0;
    res_t exp_q[$];
    res_t exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_serial_adder_if #(.WIDTH(W)) bus ();
    digit_serial_adder_if #(.WIDTH(W)) bus1 ();

    digit_serial_adder #(.WIDTH(W), .DIGIT(4))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    digit_serial_adder #(.WIDTH(W), .DIGIT(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t         r;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.s    = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Drive one operand set until accepted; acc is the number of the accepting posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output int acc, output bit to);
        to  = 1'b1;
        acc = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc = cyc + 1;
                to  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int at, output bit to);
        to = 1'b1;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                at = cyc;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        compared++; if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        compared++; if (bus.s !== '0)           begin mismatched++; $display("FAIL reset_s: got %h want 0", bus.s); end
        compared++; if (bus.cout !== 1'b0)      begin mismatched++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        compared++; if (bus.ovf !== 1'b0)       begin mismatched++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
        compared++; if (bus1.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready1: got %b want 1", bus1.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        int acc, at; bit ito, to; res_t e;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, acc, ito);
        wait_out(30, at, to);
        compared++;
        if (ito || to) begin
            mismatched++; $display("FAIL wrap_handshake: got timeout want accept and out_valid");
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            compared++; if (at - acc != 8)  begin mismatched++; $display("FAIL wrap_latency: got %0d want 8", at - acc); end
            compared++; if (bus.s !== e.s)  begin mismatched++; $display("FAIL wrap_s: got %h want %h", bus.s, e.s); end
            compared++; if (bus.cout !== e.cout) begin mismatched++; $display("FAIL wrap_cout: got %b want %b", bus.cout, e.cout); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta[4] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h8000_0000};
        logic [W-1:0] tb[4] = '{32'h0000_0007, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
        int acc, at; bit ito, to; res_t e;
        for (int k = 0; k < 4; k++) begin
            issue(ta[k], tb[k], 1'b1, 1'b1, acc, ito);
            wait_out(30, at, to);
            compared++;
            if (ito || to) begin
                mismatched++; $display("FAIL sub_handshake[%0d]: got timeout want out_valid", k);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                compared++; if (bus.s !== e.s) begin mismatched++; $display("FAIL sub_s[%0d]: got %h want %h", k, bus.s, e.s); end
                compared++; if (bus.cout !== e.cout) begin mismatched++; $display("FAIL sub_cout[%0d]: got %b want %b", k, bus.cout, e.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                compared++; if (bus.ovf !== e.ovf) begin mismatched++; $display("FAIL sub_ovf[%0d]: got %b want %b", k, bus.ovf, e.ovf); end
`endif
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, acc2, at, hs; bit ito, to; res_t e;
        issue(32'h0000_00AA, 32'h0000_0055, 1'b1, 1'b0, acc, ito);
        wait_out(30, at, to);
        compared++;
        if (ito || to) begin
            mismatched++; $display("FAIL bp_first: got timeout want out_valid");
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        bus.a = 32'h1357_9BDF; bus.b = 32'h0246_8ACE; bus.cin = 1'b0; bus.sub = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++; if (bus.s !== e.s)         begin mismatched++; $display("FAIL bp_hold_s[%0d]: got %h want %h", i, bus.s, e.s); end
            compared++; if (bus.cout !== e.cout)   begin mismatched++; $display("FAIL bp_hold_cout[%0d]: got %b want %b", i, bus.cout, e.cout); end
            compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_after_hs: got %b want 1", bus.in_ready); end
        exp_q.push_back(model(32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b1));
        acc2 = hs + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(30, at, to);
        compared++;
        if (to) begin
            mismatched++; $display("FAIL bp_second: got timeout want out_valid");
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            compared++; if (at - acc2 != 8) begin mismatched++; $display("FAIL bp_second_latency: got %0d want 8", at - acc2); end
            compared++; if (bus.s !== e.s)  begin mismatched++; $display("FAIL bp_second_s: got %h want %h", bus.s, e.s); end
            compared++; if (bus.cout !== e.cout) begin mismatched++; $display("FAIL bp_second_cout: got %b want %b", bus.cout, e.cout); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_abort();
        int acc, seen; bit ito;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, acc, ito);
        compared++; if (ito) begin mismatched++; $display("FAIL abort_accept: got timeout want accept"); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++; if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); end
        compared++; if (bus.s !== '0)           begin mismatched++; $display("FAIL abort_s: got %h want 0", bus.s); end
        compared++; if (bus.cout !== 1'b0)      begin mismatched++; $display("FAIL abort_cout: got %b want 0", bus.cout); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL abort_idle: got in_ready %b want 1", bus.in_ready); end
    endtask

    task automatic test_ndig1();
        logic [W-1:0] ta[3] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0005};
        logic [W-1:0] tb[3] = '{32'h1111_1111, 32'h0000_0001, 32'h0000_0007};
        logic         tc[3] = '{1'b1, 1'b0, 1'b0};
        logic         ts[3] = '{1'b0, 1'b0, 1'b1};
        int acc, at; res_t e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus1.a = ta[k]; bus1.b = tb[k]; bus1.cin = tc[k]; bus1.sub = ts[k]; bus1.in_valid = 1'b1;
            compared++;
            if (bus1.in_ready !== 1'b1) begin
                mismatched++; $display("FAIL ndig1_ready[%0d]: got %b want 1", k, bus1.in_ready);
            end else begin
                exp1_q.push_back(model(ta[k], tb[k], tc[k], ts[k]));
                acc = cyc + 1;
                @(negedge clk);
                bus1.in_valid = 1'b0;
                at = -1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (bus1.out_valid === 1'b1) begin at = cyc; break; end
                end
                e = exp1_q.pop_front();
                compared++; if (at - acc != 1)    begin mismatched++; $display("FAIL ndig1_latency[%0d]: got %0d want 1", k, at - acc); end
                compared++; if (bus1.s !== e.s)   begin mismatched++; $display("FAIL ndig1_s[%0d]: got %h want %h", k, bus1.s, e.s); end
                compared++; if (bus1.cout !== e.cout) begin mismatched++; $display("FAIL ndig1_cout[%0d]: got %b want %b", k, bus1.cout, e.cout); end
                bus1.out_ready = 1'b1;
                @(negedge clk);
                bus1.out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, prev, at; bit ito, to; res_t e;
        logic [W-1:0] ra, rb; logic rc, rs;
        prev = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, rs, acc, ito);
            wait_out(30, at, to);
            compared++;
            if (ito || to) begin
                mismatched++; $display("FAIL b2b_handshake[%0d]: got timeout want out_valid", k);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if (k > 0) begin
                    compared++; if (acc - prev != 10) begin mismatched++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", k, acc - prev); end
                end
                compared++; if (bus.s !== e.s)       begin mismatched++; $display("FAIL b2b_s[%0d]: got %h want %h", k, bus.s, e.s); end
                compared++; if (bus.cout !== e.cout) begin mismatched++; $display("FAIL b2b_cout[%0d]: got %b want %b", k, bus.cout, e.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                compared++; if (bus.ovf !== e.ovf)   begin mismatched++; $display("FAIL b2b_ovf[%0d]: got %b want %b", k, bus.ovf, e.ovf); end
`endif
            end
            prev = acc;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic [W-1:0] tb[3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        logic         ts[3] = '{1'b0, 1'b1, 1'b0};
        logic         tv[3] = '{1'b1, 1'b1, 1'b0};
        int acc, at; bit ito, to; res_t e;
        for (int k = 0; k < 3; k++) begin
            issue(ta[k], tb[k], 1'b0, ts[k], acc, ito);
            wait_out(30, at, to);
            compared++;
            if (ito || to) begin
                mismatched++; $display("FAIL ovf_handshake[%0d]: got timeout want out_valid", k);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                compared++; if (bus.ovf !== tv[k]) begin mismatched++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, bus.ovf, tv[k]); end
                compared++; if (bus.s !== e.s)     begin mismatched++; $display("FAIL ovf_s[%0d]: got %h want %h", k, bus.s, e.s); end
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        test_reset();
        test_wrap();
        test_sub();
        test_backpressure();
        test_abort();
        test_ndig1();
        test_back_to_back();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
